// File: rtl/axi_lite_timer_if.sv
// AXI_LITE -- AXI4-Lite bundle used by the timer register port.
//   Slave modport  : the register block (drives ready on AW/W/AR, owns B and R).
//   Master modport : the upstream converter / bench side.
// Channel signals:
//   aw: aw_addr, aw_prot, aw_valid, aw_ready
//   w : w_data, w_strb, w_valid, w_ready
//   b : b_resp, b_valid, b_ready
//   ar: ar_addr, ar_prot, ar_valid, ar_ready
//   r : r_data, r_resp, r_valid, r_ready
interface AXI_LITE #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;

  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport Slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );

  modport Master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi_lite_timer.sv
// axi_lite_timer -- free-running 32-bit up-counter with compare match,
// optional auto-reload and a level interrupt, controlled over AXI4-Lite.
//
// Ports:
//   aclk   in   single clock, rising edge
//   areset in   synchronous active-high reset
//   slv    AXI_LITE.Slave register port (DATA_WIDTH must be 32)
//   irq    out  level interrupt = PENDING & IRQ_EN
//
// Register map (offset = addr[11:0], addr[1:0] ignored):
//   0x0 CTRL    RW  bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   0x4 COUNT   RW  32-bit counter
//   0x8 COMPARE RW  32-bit match value
//   0xC STATUS  W1C bit0 PENDING
//   other       SLVERR, reads return 0
module axi_lite_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic   aclk,
  input  logic   areset,
  AXI_LITE.Slave slv,
  output logic   irq
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // register state
  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] compare;
  logic        pending;

  // response channel state
  logic        b_valid_q;
  logic [1:0]  b_resp_q;
  logic        r_valid_q;
  logic [31:0] r_data_q;
  logic [1:0]  r_resp_q;

  logic        en;
  logic        auto_reload;
  logic        irq_en;

  assign en          = ctrl[0];
  assign auto_reload = ctrl[1];
  assign irq_en      = ctrl[2];

  // Address, prot and low address bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{slv.aw_addr[ADDR_WIDTH-1:12], slv.aw_addr[1:0],
                         slv.ar_addr[ADDR_WIDTH-1:12], slv.ar_addr[1:0],
                         slv.aw_prot, slv.ar_prot};

  // ---------------------------------------------------------------------
  // Handshakes: AW and W are only accepted together, one write and one
  // read outstanding at most, and nothing is accepted while in reset.
  // ---------------------------------------------------------------------
  logic wr_hs;
  logic rd_hs;

  assign wr_hs        = slv.aw_valid & slv.w_valid & ~b_valid_q & ~areset;
  assign slv.aw_ready = wr_hs;
  assign slv.w_ready  = wr_hs;

  assign slv.ar_ready = ~r_valid_q & ~areset;
  assign rd_hs        = slv.ar_valid & ~r_valid_q & ~areset;

  assign slv.b_valid  = b_valid_q;
  assign slv.b_resp   = b_resp_q;
  assign slv.r_valid  = r_valid_q;
  assign slv.r_data   = r_data_q;
  assign slv.r_resp   = r_resp_q;

  assign irq = pending & irq_en;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  logic [9:0]        wr_word;
  logic              wr_mapped;
  logic [1:0]        wr_resp;
  logic [31:0]       wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wr_ctrl;
  logic              wr_count;
  logic              wr_compare;
  logic              wr_status;

  assign wdata = slv.w_data;
  assign wstrb = slv.w_strb;

  always_comb begin
    wr_word    = slv.aw_addr[11:2];
    wr_mapped  = (wr_word[9:2] == 8'd0);
    wr_resp    = wr_mapped ? RESP_OKAY : RESP_SLVERR;
    wr_ctrl    = wr_hs & wr_mapped & (wr_word[1:0] == REG_CTRL);
    wr_count   = wr_hs & wr_mapped & (wr_word[1:0] == REG_COUNT);
    wr_compare = wr_hs & wr_mapped & (wr_word[1:0] == REG_COMPARE);
    wr_status  = wr_hs & wr_mapped & (wr_word[1:0] == REG_STATUS);
  end

  // ---------------------------------------------------------------------
  // Counter datapath. The software write is merged on top of the value
  // the counter would otherwise take, so unwritten bytes still advance.
  // ---------------------------------------------------------------------
  logic        match;
  logic [31:0] count_step;
  logic [31:0] count_next;
  logic [31:0] compare_next;
  logic [2:0]  ctrl_next;
  logic        pending_next;

  always_comb begin
    match = en & (count == compare);

    if (!en)                       count_step = count;
    else if (match && auto_reload) count_step = 32'd0;
    else                           count_step = count + 32'd1;

    count_next   = wr_count   ? merge_bytes(count_step, wdata, wstrb) : count_step;
    compare_next = wr_compare ? merge_bytes(compare, wdata, wstrb)    : compare;
    ctrl_next    = (wr_ctrl && wstrb[0]) ? wdata[2:0] : ctrl;

    // A match outranks a same-cycle clear so no event is lost.
    if (match)                                    pending_next = 1'b1;
    else if (wr_status && wstrb[0] && wdata[0])   pending_next = 1'b0;
    else                                          pending_next = pending;
  end

  // ---------------------------------------------------------------------
  // Read decode: sampled from current register values, so a read that
  // coincides with a write to the same register sees the old contents.
  // ---------------------------------------------------------------------
  logic [9:0]  rd_word;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  always_comb begin
    rd_word = slv.ar_addr[11:2];
    rd_data = 32'd0;
    rd_resp = RESP_OKAY;
    if (rd_word[9:2] != 8'd0) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (rd_word[1:0])
        REG_CTRL:    rd_data = {29'd0, ctrl};
        REG_COUNT:   rd_data = count;
        REG_COMPARE: rd_data = compare;
        default:     rd_data = {31'd0, pending};
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      ctrl      <= 3'd0;
      count     <= 32'd0;
      compare   <= 32'd0;
      pending   <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_data_q  <= 32'd0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      ctrl    <= ctrl_next;
      count   <= count_next;
      compare <= compare_next;
      pending <= pending_next;

      if (wr_hs) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_resp;
      end else if (slv.b_ready) begin
        b_valid_q <= 1'b0;
      end

      if (rd_hs) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data;
        r_resp_q  <= rd_resp;
      end else if (slv.r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_timer.sv
module tb_axi_lite_timer;

  logic aclk;
  logic areset;
  logic irq;

  AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) slv_if ();

  axi_lite_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk   (aclk),
    .areset (areset),
    .slv    (slv_if),
    .irq    (irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int tests;
  int fails;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Call at a falling edge; returns on the falling edge after the handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    n = 0;
    slv_if.aw_addr  = addr;
    slv_if.w_data   = data;
    slv_if.w_strb   = strb;
    slv_if.aw_valid = 1'b1;
    slv_if.w_valid  = 1'b1;
    #1;
    while (!(slv_if.aw_ready && slv_if.w_ready) && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    check("wr_accept", {31'd0, slv_if.aw_ready}, 32'd1);
    @(posedge aclk); #1;
    slv_if.aw_valid = 1'b0;
    slv_if.w_valid  = 1'b0;
    @(negedge aclk);
    check("wr_bvalid", {31'd0, slv_if.b_valid}, 32'd1);
    resp = slv_if.b_resp;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    n = 0;
    slv_if.ar_addr  = addr;
    slv_if.ar_valid = 1'b1;
    #1;
    while (!slv_if.ar_ready && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    check("rd_accept", {31'd0, slv_if.ar_ready}, 32'd1);
    @(posedge aclk); #1;
    slv_if.ar_valid = 1'b0;
    @(negedge aclk);
    check("rd_rvalid", {31'd0, slv_if.r_valid}, 32'd1);
    data = slv_if.r_data;
    resp = slv_if.r_resp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_cnt [7];
    logic [31:0] wrap_cnt [4];

    tests = 0;
    fails = 0;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0008, 32'h0000_0010, 4'hF, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0000_0010};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'h2, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h1122_CC44};
    vecs[11] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h0000_0010};
    vecs[13] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF8, 4'hF, 2'b00, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0};
    vecs[15] = '{1'b0, 32'h1234_500A, 32'h0,         4'h0, 2'b00, 32'h0000_0010};
    vecs[16] = '{1'b1, 32'h0000_0000, 32'h0000_FF02, 4'h1, 2'b00, 32'h0};
    vecs[17] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0000_0002};
    vecs[18] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[19] = '{1'b1, 32'h0000_0000, 32'h0,         4'hF, 2'b00, 32'h0};

    exp_cnt  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2};
    wrap_cnt = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};

    slv_if.aw_addr = '0; slv_if.aw_prot = '0; slv_if.aw_valid = 1'b0;
    slv_if.w_data  = '0; slv_if.w_strb  = '0; slv_if.w_valid  = 1'b0;
    slv_if.b_ready = 1'b1;
    slv_if.ar_addr = '0; slv_if.ar_prot = '0; slv_if.ar_valid = 1'b0;
    slv_if.r_ready = 1'b1;
    areset = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    slv_if.aw_valid = 1'b1;
    slv_if.w_valid  = 1'b1;
    #1;
    check("rst_aw_ready", {31'd0, slv_if.aw_ready}, 32'd0);
    check("rst_ar_ready", {31'd0, slv_if.ar_ready}, 32'd0);
    check("rst_b_valid",  {31'd0, slv_if.b_valid},  32'd0);
    check("rst_r_valid",  {31'd0, slv_if.r_valid},  32'd0);
    check("rst_irq",      {31'd0, irq},             32'd0);
    check("rst_r_data",   slv_if.r_data,            32'd0);
    slv_if.aw_valid = 1'b0;
    slv_if.w_valid  = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    // ---------------- table vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_write) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, rdata, resp);
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
      end
    end

    // ---------------- simultaneous read and write of COMPARE ----------------
    @(negedge aclk);
    slv_if.aw_addr = 32'h8; slv_if.w_data = 32'h77; slv_if.w_strb = 4'hF;
    slv_if.aw_valid = 1'b1; slv_if.w_valid = 1'b1;
    slv_if.ar_addr = 32'h8; slv_if.ar_valid = 1'b1;
    #1;
    check("rw_both_ready", {30'd0, slv_if.aw_ready, slv_if.ar_ready}, 32'd3);
    @(posedge aclk); #1;
    slv_if.aw_valid = 1'b0; slv_if.w_valid = 1'b0; slv_if.ar_valid = 1'b0;
    @(negedge aclk);
    check("rw_old_value", slv_if.r_data, 32'h10);
    @(negedge aclk);
    axi_read(32'h8, rdata, resp);
    check("rw_new_value", rdata, 32'h77);

    // ---------------- auto-reload ----------------
    @(negedge aclk);
    axi_write(32'h8, 32'd3, 4'hF, resp);
    axi_write(32'h4, 32'd0, 4'hF, resp);
    axi_write(32'hC, 32'd1, 4'hF, resp);
    axi_write(32'h0, 32'h7, 4'hF, resp);
    check("ar_count_c0", dut.count, exp_cnt[0]);
    check("ar_irq_c0", {31'd0, irq}, 32'd0);
    for (int k = 1; k < 7; k++) begin
      @(negedge aclk);
      check($sformatf("ar_count_c%0d", k), dut.count, exp_cnt[k]);
      check($sformatf("ar_irq_c%0d", k), {31'd0, irq}, (k >= 4) ? 32'd1 : 32'd0);
    end
    axi_write(32'hC, 32'd1, 4'hF, resp);          // handshake at end of c6
    check("ar_irq_cleared", {31'd0, irq}, 32'd0);  // c7
    @(negedge aclk);
    check("ar_irq_refire", {31'd0, irq}, 32'd1);   // c8, after c7 match
    axi_write(32'hC, 32'd1, 4'hF, resp);           // clear at end of c8
    check("pri_irq_pre", {31'd0, irq}, 32'd0);     // c9
    @(negedge aclk);
    @(negedge aclk);
    check("pri_count_c11", dut.count, 32'd3);
    axi_write(32'hC, 32'd1, 4'hF, resp);           // clear coincident with match
    check("pri_match_wins", {31'd0, irq}, 32'd1);
    axi_write(32'h0, 32'h0, 4'hF, resp);

    // ---------------- backpressure ----------------
    @(negedge aclk);
    slv_if.b_ready = 1'b0;
    axi_write(32'h10, 32'h1234, 4'hF, resp);
    check("bp_first_resp", {30'd0, resp}, 32'd2);
    slv_if.aw_addr = 32'h8; slv_if.w_data = 32'h55; slv_if.w_strb = 4'hF;
    slv_if.aw_valid = 1'b1; slv_if.w_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), {30'd0, slv_if.aw_ready, slv_if.w_ready}, 32'd0);
      check($sformatf("bp_b_%0d", k), {29'd0, slv_if.b_valid, slv_if.b_resp}, 32'h6);
      @(negedge aclk);
    end
    slv_if.b_ready = 1'b1;
    @(posedge aclk); #1;
    check("bp_ready_release", {31'd0, slv_if.aw_ready}, 32'd1);
    @(posedge aclk); #1;
    slv_if.aw_valid = 1'b0; slv_if.w_valid = 1'b0;
    @(negedge aclk);
    check("bp_second_b", {29'd0, slv_if.b_valid, slv_if.b_resp}, 32'h4);
    axi_read(32'h8, rdata, resp);
    check("bp_second_data", rdata, 32'h55);

    // ---------------- wrap, no reload ----------------
    @(negedge aclk);
    axi_write(32'hC, 32'd1, 4'hF, resp);
    axi_write(32'h4, 32'hFFFF_FFFE, 4'hF, resp);
    axi_write(32'h8, 32'h1, 4'hF, resp);
    axi_write(32'h0, 32'h1, 4'hF, resp);
    check("wr_count_c0", dut.count, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      check($sformatf("wrap_count_%0d", k), dut.count, wrap_cnt[k]);
      check($sformatf("wrap_irq_%0d", k), {31'd0, irq}, 32'd0);
    end
    axi_write(32'h0, 32'h0, 4'hF, resp);
    axi_read(32'hC, rdata, resp);
    check("wrap_pending", rdata, 32'd1);
    axi_read(32'h4, rdata, resp);
    check("wrap_count_held", rdata, 32'd3);
    check("wrap_irq_off", {31'd0, irq}, 32'd0);

    // ---------------- reset mid-transaction ----------------
    axi_write(32'h0, 32'h4, 4'hF, resp);
    check("rs_irq_on", {31'd0, irq}, 32'd1);
    @(negedge aclk);
    slv_if.r_ready = 1'b0;
    axi_read(32'h8, rdata, resp);
    @(negedge aclk);
    check("rs_r_hold", {slv_if.r_data[30:0], slv_if.r_valid}, {31'h1, 1'b1});
    areset = 1'b1;
    slv_if.ar_valid = 1'b1;
    slv_if.aw_valid = 1'b1; slv_if.w_valid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("rs_r_valid", {31'd0, slv_if.r_valid}, 32'd0);
    check("rs_irq", {31'd0, irq}, 32'd0);
    check("rs_readies", {29'd0, slv_if.aw_ready, slv_if.w_ready, slv_if.ar_ready}, 32'd0);
    check("rs_r_data", slv_if.r_data, 32'd0);
    slv_if.ar_valid = 1'b0;
    slv_if.aw_valid = 1'b0; slv_if.w_valid = 1'b0;
    slv_if.r_ready = 1'b1;
    areset = 1'b0;
    @(negedge aclk);
    for (int a = 0; a < 4; a++) begin
      axi_read(32'(a * 4), rdata, resp);
      check($sformatf("rs_reg%0d", a), rdata, 32'd0);
    end

    @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
